// File: rtl/cont_mod_n.sv
// cont_mod_n: modulo-MOD up/down counter advanced by a divided-clock tick,
// with synchronous clamped load, cascade carry (tc) and an active-low
// seven-segment decode of the low nibble of the count.
module cont_mod_n #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             key,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             tick,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [0:6]       s
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WIDTH-1:0] Q_LAST   = WIDTH'(MOD - 1);
  // One extra bit so that MOD == 2**WIDTH is still representable.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic [WIDTH-1:0] d_clamped;
  logic             terminal;
  logic [WIDTH-1:0] q_next;
  logic [3:0]       nib;

  assign div_last = (div_cnt == DIV_LAST);

  // Free-running divider; tick is registered one cycle after DIV-1 is reached.
  // With DIV == 1 the divider sits at 0 and tick stays high after reset.
  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= div_last;
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
    end
  end

  // Load clamp, terminal detect and next-count selection (load wins over count).
  always_comb begin
    d_clamped = ({1'b0, d} >= MOD_EXT) ? Q_LAST : d;
    terminal  = up ? (q == Q_LAST) : (q == '0);
    q_next    = q;
    if (load) begin
      q_next = d_clamped;
    end else if (tick && en) begin
      if (up) begin
        q_next = (q == Q_LAST) ? '0 : q + 1'b1;
      end else begin
        q_next = (q == '0) ? Q_LAST : q - 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Carry is coincident with the wrap edge so a cascaded stage can use en = tc.
  assign tc = tick & en & ~load & terminal;

  // Narrow counters are zero-extended to a full nibble before decoding.
  if (WIDTH >= 4) begin : g_nib
    assign nib = q[3:0];
  end else begin : g_nib_ext
    assign nib = {{(4 - WIDTH){1'b0}}, q};
  end

  // Hex to active-low segments; literal bit order is a,b,c,d,e,f,g.
  always_comb begin
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_cont_mod_n.sv
// Directed bench for cont_mod_n: single counter (DIV=4, MOD=10) and a
// two-digit decimal cascade (DIV=1).
module tb_cont_mod_n;

  logic       clk = 1'b0;
  logic       key_a, en_a, up_a, load_a;
  logic [3:0] d_a;
  logic       tick_a, tc_a;
  logic [3:0] q_a;
  logic [0:6] s_a;

  logic       key_b;
  logic       tick1, tc1, tick2, tc2;
  logic [3:0] q1, q2;
  logic [0:6] s1, s2;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clk = ~clk;

  cont_mod_n #(.WIDTH(4), .MOD(10), .DIV(4)) dut (
    .clk(clk), .key(key_a), .en(en_a), .up(up_a), .load(load_a), .d(d_a),
    .tick(tick_a), .q(q_a), .tc(tc_a), .s(s_a)
  );

  cont_mod_n #(.WIDTH(4), .MOD(10), .DIV(1)) ones (
    .clk(clk), .key(key_b), .en(1'b1), .up(1'b1), .load(1'b0), .d(4'd0),
    .tick(tick1), .q(q1), .tc(tc1), .s(s1)
  );

  cont_mod_n #(.WIDTH(4), .MOD(10), .DIV(1)) tens (
    .clk(clk), .key(key_b), .en(tc1), .up(1'b1), .load(1'b0), .d(4'd0),
    .tick(tick2), .q(q2), .tc(tc2), .s(s2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until tick is seen; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_a && n < 20);
    if (!tick_a) check("tick_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp;
    key_a = 1'b0; en_a = 1'b1; up_a = 1'b1; load_a = 1'b0; d_a = 4'd0;
    key_b = 1'b0;
    #1;
    check("rst_q", 32'(q_a), 0);
    check("rst_tick", 32'(tick_a), 0);
    check("rst_tc", 32'(tc_a), 0);
    check("rst_s", 32'(s_a), 32'(7'b0000001));
    check("rst_casc_q", 32'({q2, q1}), 0);
    @(negedge clk);
    check("rst_hold_q", 32'(q_a), 0);
    check("rst_hold_tick", 32'(tick_a), 0);
    check("rst_hold_tick1", 32'(tick1), 0);

    // Up count, 40 ticks
    key_a = 1'b1;
    wait_tick(n);
    check("first_tick_lat", n, 4);
    exp = 0;
    for (int k = 0; k < 40; k++) begin
      check("up_q", 32'(q_a), exp);
      check("up_tc", 32'(tc_a), (exp == 9) ? 1 : 0);
      check("up_s", 32'(s_a), 32'(seg_tab[exp]));
      exp = (exp == 9) ? 0 : exp + 1;
      @(negedge clk);
      check("up_tick_low", 32'(tick_a), 0);
      check("up_q_next", 32'(q_a), exp);
      wait_tick(n);
      check("up_tick_period", n, 3);
    end

    // Down count from reset
    @(negedge clk);
    key_a = 1'b0; up_a = 1'b0;
    @(negedge clk);
    key_a = 1'b1;
    wait_tick(n);
    check("dn_first_tick_lat", n, 4);
    exp = 0;
    for (int k = 0; k < 11; k++) begin
      check("dn_q", 32'(q_a), exp);
      check("dn_tc", 32'(tc_a), (exp == 0) ? 1 : 0);
      exp = (exp == 0) ? 9 : exp - 1;
      @(negedge clk);
      wait_tick(n);
    end
    // At a tick cycle with q=9; the next edge counts down to 8.
    @(negedge clk);
    check("dn_q_8", 32'(q_a), 8);

    // Loads: non-tick, clamped, and on a tick
    up_a = 1'b1; load_a = 1'b1; d_a = 4'd6;
    @(negedge clk);
    check("ld_q_6", 32'(q_a), 6);
    check("ld_tick_low", 32'(tick_a), 0);
    d_a = 4'd13;
    @(negedge clk);
    check("ld_clamp", 32'(q_a), 9);
    load_a = 1'b0;
    @(negedge clk);
    check("ld_tick_here", 32'(tick_a), 1);
    check("ld_tc_nolod", 32'(tc_a), 1);
    load_a = 1'b1; d_a = 4'd3;
    #1;
    check("ld_tc_masked", 32'(tc_a), 0);
    @(negedge clk);
    check("ld_on_tick", 32'(q_a), 3);

    // Enable low holds the count while tick keeps pulsing
    d_a = 4'd5; en_a = 1'b0;
    @(negedge clk);
    check("hold_load5", 32'(q_a), 5);
    load_a = 1'b0;
    wait_tick(n);
    check("hold_tick_lat", n, 2);
    for (int k = 0; k < 3; k++) begin
      check("hold_q", 32'(q_a), 5);
      check("hold_tc", 32'(tc_a), 0);
      if (k < 2) begin
        wait_tick(n);
        check("hold_tick_period", n, 4);
      end
    end
    en_a = 1'b1;
    @(negedge clk);
    check("hold_resume", 32'(q_a), 6);

    // Async reset between edges at q=7
    load_a = 1'b1; d_a = 4'd7;
    @(negedge clk);
    load_a = 1'b0;
    check("ar_q7", 32'(q_a), 7);
    wait_tick(n);
    check("ar_tick_lat", n, 2);
    check("ar_tick_before", 32'(tick_a), 1);
    #2;
    key_a = 1'b0;
    #1;
    check("ar_q", 32'(q_a), 0);
    check("ar_tick", 32'(tick_a), 0);
    check("ar_tc", 32'(tc_a), 0);
    check("ar_s", 32'(s_a), 32'(7'b0000001));
    @(negedge clk);
    key_a = 1'b1;
    wait_tick(n);
    check("ar_release_lat", n, 4);
    check("ar_q_after", 32'(q_a), 0);

    // Two-digit cascade, DIV=1
    key_b = 1'b1;
    @(negedge clk);
    check("casc_tick1", 32'(tick1), 1);
    check("casc_tick2", 32'(tick2), 1);
    for (int v = 0; v <= 100; v++) begin
      check("casc_ones", 32'(q1), v % 10);
      check("casc_tens", 32'(q2), (v / 10) % 10);
      check("casc_tc2", 32'(tc2), (v == 99) ? 1 : 0);
      check("casc_s1", 32'(s1), 32'(seg_tab[v % 10]));
      check("casc_s2", 32'(s2), 32'(seg_tab[(v / 10) % 10]));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
